// File: rtl/registers_bank_mp_pkg.sv
// Shared defaults and dump FSM state type for the multi-port register bank.
package registers_bank_mp_pkg;

    localparam int unsigned DEFAULT_REGISTERS_BANK_SIZE = 32;
    localparam int unsigned DEFAULT_REGISTERS_SIZE      = 32;
    localparam int unsigned DEFAULT_READ_PORTS          = 2;
    localparam int unsigned WRITE_PORTS                 = 2;

    typedef enum logic {
        DUMP_IDLE = 1'b0,
        DUMP_SEND = 1'b1
    } dump_state_e;

endpackage

// File: rtl/registers_bank_mp_dump_fsm.sv
// Debug dump sequencer: walks the bank index over a valid/ready channel.
module registers_bank_dump_fsm
    import registers_bank_mp_pkg::*;
#(
    parameter int unsigned REGISTERS_BANK_SIZE = DEFAULT_REGISTERS_BANK_SIZE,
    parameter int unsigned REGISTERS_SIZE      = DEFAULT_REGISTERS_SIZE,
    localparam int unsigned AW                 = $clog2(REGISTERS_BANK_SIZE)
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_dump_start,
    input  logic                      i_dump_ready,
    input  logic [REGISTERS_SIZE-1:0] i_data,
    output logic                      o_dump_valid,
    output logic [REGISTERS_SIZE-1:0] o_dump_data,
    output logic [AW-1:0]             o_dump_index,
    output logic                      o_dump_last,
    output logic                      o_dump_busy
);

    localparam logic [AW-1:0] LAST_INDEX = AW'(REGISTERS_BANK_SIZE - 1);

    dump_state_e   state_q, state_d;
    logic [AW-1:0] index_q, index_d;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= DUMP_IDLE;
            index_q <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        o_dump_valid = 1'b0;
        o_dump_busy  = 1'b0;
        o_dump_last  = 1'b0;
        unique case (state_q)
            DUMP_IDLE: begin
                if (i_dump_start) begin
                    state_d = DUMP_SEND;
                    index_d = '0;
                end
            end
            DUMP_SEND: begin
                o_dump_valid = 1'b1;
                o_dump_busy  = 1'b1;
                o_dump_last  = (index_q == LAST_INDEX);
                // start is deliberately not looked at here: a dump cannot restart itself
                if (i_dump_ready) begin
                    if (index_q == LAST_INDEX) begin
                        state_d = DUMP_IDLE;
                        index_d = '0;
                    end else begin
                        index_d = index_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = DUMP_IDLE;
                index_d = '0;
            end
        endcase
    end

    assign o_dump_index = index_q;
    assign o_dump_data  = i_data;

endmodule

// File: rtl/registers_bank_mp.sv
// Multi-port register file: two prioritised write ports, bypassed registered reads, debug dump.
module registers_bank_mp
    import registers_bank_mp_pkg::*;
#(
    parameter int unsigned REGISTERS_BANK_SIZE = DEFAULT_REGISTERS_BANK_SIZE,
    parameter int unsigned REGISTERS_SIZE      = DEFAULT_REGISTERS_SIZE,
    parameter int unsigned READ_PORTS          = DEFAULT_READ_PORTS,
    parameter int unsigned ZERO_REG_HARDWIRED  = 1,
    localparam int unsigned AW                 = $clog2(REGISTERS_BANK_SIZE)
) (
    input  logic                                 i_clk,
    input  logic                                 i_reset,
    input  logic [WRITE_PORTS-1:0]               i_we,
    input  logic [WRITE_PORTS*AW-1:0]            i_addr_wr,
    input  logic [WRITE_PORTS*REGISTERS_SIZE-1:0] i_bus_wr,
    input  logic [READ_PORTS*AW-1:0]             i_addr_rd,
    output logic [READ_PORTS*REGISTERS_SIZE-1:0] o_bus_rd,
    input  logic                                 i_dump_start,
    input  logic                                 i_dump_ready,
    output logic                                 o_dump_valid,
    output logic [REGISTERS_SIZE-1:0]            o_dump_data,
    output logic [AW-1:0]                        o_dump_index,
    output logic                                 o_dump_last,
    output logic                                 o_dump_busy
);

    localparam int unsigned W = REGISTERS_SIZE;

    logic [W-1:0] regs_q [REGISTERS_BANK_SIZE];
    logic [W-1:0] regs_d [REGISTERS_BANK_SIZE];

    // Later ports overwrite earlier ones, so port 1 wins an address collision.
    always_comb begin
        regs_d = regs_q;
        for (int unsigned k = 0; k < WRITE_PORTS; k++) begin
            if (i_we[k] &&
                !((ZERO_REG_HARDWIRED != 0) && (i_addr_wr[k*AW +: AW] == '0))) begin
                regs_d[i_addr_wr[k*AW +: AW]] = i_bus_wr[k*W +: W];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // Reading the post-write view gives same-cycle bypass with write priority for free.
    for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
        logic [W-1:0] rd_q;

        always_ff @(posedge i_clk) begin
            if (i_reset) begin
                rd_q <= '0;
            end else begin
                rd_q <= regs_d[i_addr_rd[p*AW +: AW]];
            end
        end

        assign o_bus_rd[p*W +: W] = rd_q;
    end

    logic [AW-1:0] dump_index;

    registers_bank_dump_fsm #(
        .REGISTERS_BANK_SIZE (REGISTERS_BANK_SIZE),
        .REGISTERS_SIZE      (REGISTERS_SIZE)
    ) u_dump_fsm (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_dump_start (i_dump_start),
        .i_dump_ready (i_dump_ready),
        .i_data       (regs_q[dump_index]),
        .o_dump_valid (o_dump_valid),
        .o_dump_data  (o_dump_data),
        .o_dump_index (dump_index),
        .o_dump_last  (o_dump_last),
        .o_dump_busy  (o_dump_busy)
    );

    assign o_dump_index = dump_index;

endmodule

// File: tb/tb_registers_bank_mp.sv
// Self-checking bench: directed vector table, dump sequences and randomized traffic vs a reference model.
module tb_registers_bank_mp;

    localparam int N  = 32;
    localparam int AW = 5;
    localparam int W  = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      we;
    logic [2*AW-1:0] addr_wr;
    logic [2*W-1:0]  bus_wr;
    logic [2*AW-1:0] addr_rd;
    logic            start, ready;

    logic [2*W-1:0]  bus_rd [2];
    logic            dvalid [2];
    logic [W-1:0]    ddata  [2];
    logic [AW-1:0]   dindex [2];
    logic            dlast  [2];
    logic            dbusy  [2];

    always #5 clk = ~clk;

    registers_bank_mp #(
        .REGISTERS_BANK_SIZE (N),
        .REGISTERS_SIZE      (W),
        .READ_PORTS          (2),
        .ZERO_REG_HARDWIRED  (1)
    ) dut_z (
        .i_clk (clk), .i_reset (rst), .i_we (we), .i_addr_wr (addr_wr), .i_bus_wr (bus_wr),
        .i_addr_rd (addr_rd), .o_bus_rd (bus_rd[0]), .i_dump_start (start), .i_dump_ready (ready),
        .o_dump_valid (dvalid[0]), .o_dump_data (ddata[0]), .o_dump_index (dindex[0]),
        .o_dump_last (dlast[0]), .o_dump_busy (dbusy[0])
    );

    registers_bank_mp #(
        .REGISTERS_BANK_SIZE (N),
        .REGISTERS_SIZE      (W),
        .READ_PORTS          (2),
        .ZERO_REG_HARDWIRED  (0)
    ) dut_nz (
        .i_clk (clk), .i_reset (rst), .i_we (we), .i_addr_wr (addr_wr), .i_bus_wr (bus_wr),
        .i_addr_rd (addr_rd), .o_bus_rd (bus_rd[1]), .i_dump_start (start), .i_dump_ready (ready),
        .o_dump_valid (dvalid[1]), .o_dump_data (ddata[1]), .o_dump_index (dindex[1]),
        .o_dump_last (dlast[1]), .o_dump_busy (dbusy[1])
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: index 0 is the hard-wired-zero bank, index 1 the plain bank.
    logic [W-1:0] m    [2][N];
    logic [W-1:0] e_rd [2][2];
    bit           mbusy = 0;
    int           midx  = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] read_value(int d, int a);
        logic [W-1:0] v;
        if (d == 0 && a == 0) return '0;
        v = m[d][a];
        if (we[0] && int'(addr_wr[AW-1:0]) == a) v = bus_wr[W-1:0];
        if (we[1] && int'(addr_wr[2*AW-1:AW]) == a) v = bus_wr[2*W-1:W];
        return v;
    endfunction

    task automatic model_edge();
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                for (int a = 0; a < N; a++) m[d][a] = '0;
                e_rd[d][0] = '0;
                e_rd[d][1] = '0;
            end
            mbusy = 0;
            midx  = 0;
            return;
        end
        for (int d = 0; d < 2; d++) begin
            e_rd[d][0] = read_value(d, int'(addr_rd[AW-1:0]));
            e_rd[d][1] = read_value(d, int'(addr_rd[2*AW-1:AW]));
            for (int k = 0; k < 2; k++) begin
                int a;
                a = int'(addr_wr[k*AW +: AW]);
                if (we[k] && !(d == 0 && a == 0)) m[d][a] = bus_wr[k*W +: W];
            end
        end
        if (mbusy) begin
            if (ready) begin
                if (midx == N - 1) begin
                    mbusy = 0;
                    midx  = 0;
                end else begin
                    midx++;
                end
            end
        end else if (start) begin
            mbusy = 1;
            midx  = 0;
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rd%0d_p0", d), bus_rd[d][W-1:0], e_rd[d][0]);
            chk($sformatf("rd%0d_p1", d), bus_rd[d][2*W-1:W], e_rd[d][1]);
            chk($sformatf("dump_valid%0d", d), W'(dvalid[d]), W'(mbusy));
            if (mbusy) chk($sformatf("dump_data%0d", d), ddata[d], m[d][midx]);
        end
        chk("dump_busy", W'(dbusy[0]), W'(mbusy));
        chk("dump_index", W'(dindex[0]), W'(midx));
        chk("dump_last", W'(dlast[0]), W'(mbusy && midx == N - 1));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic set_wr(input logic [1:0] e, input int a0, input int a1,
                          input logic [W-1:0] d0, input logic [W-1:0] d1);
        we      = e;
        addr_wr = {AW'(a1), AW'(a0)};
        bus_wr  = {d1, d0};
    endtask

    task automatic set_rd(input int r0, input int r1);
        addr_rd = {AW'(r1), AW'(r0)};
    endtask

    typedef struct {
        logic [1:0]   we;
        int           wa0, wa1;
        logic [W-1:0] d0, d1;
        int           ra0, ra1;
        logic [W-1:0] x0, x1, xnz0;
    } vec_t;

    vec_t tbl [7];

    typedef struct {
        int           idx;
        logic [W-1:0] data;
        logic         last;
    } hs_t;

    hs_t hs_q [$];

    initial begin
        tbl[0] = '{2'b00, 0, 0, 32'h0,        32'h0,  3, 9, 32'h0,        32'h0,        32'h0};
        tbl[1] = '{2'b01, 5, 0, 32'hDEADBEEF, 32'h0,  5, 0, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF};
        tbl[2] = '{2'b00, 0, 0, 32'h0,        32'h0,  5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
        tbl[3] = '{2'b11, 7, 7, 32'h11,       32'h22, 7, 5, 32'h22,       32'hDEADBEEF, 32'h22};
        tbl[4] = '{2'b00, 0, 0, 32'h0,        32'h0,  7, 7, 32'h22,       32'h22,       32'h22};
        tbl[5] = '{2'b01, 0, 0, 32'hFFFFFFFF, 32'h0,  0, 7, 32'h0,        32'h22,       32'hFFFFFFFF};
        tbl[6] = '{2'b00, 0, 0, 32'h0,        32'h0,  0, 0, 32'h0,        32'h0,        32'hFFFFFFFF};

        for (int d = 0; d < 2; d++)
            for (int a = 0; a < N; a++) m[d][a] = '0;

        rst = 1'b1; start = 1'b0; ready = 1'b0;
        set_wr(2'b11, 3, 4, 32'hA5A5A5A5, 32'h5A5A5A5A);
        set_rd(3, 4);
        step();
        set_wr(2'b00, 0, 0, '0, '0);
        step();
        rst = 1'b0;

        // Every address on both ports reads zero after reset.
        for (int a = 0; a < N; a++) begin
            set_rd(a, N - 1 - a);
            step();
        end

        // Directed vectors: bypass, write priority, hard-wired zero.
        for (int i = 0; i < 7; i++) begin
            set_wr(tbl[i].we, tbl[i].wa0, tbl[i].wa1, tbl[i].d0, tbl[i].d1);
            set_rd(tbl[i].ra0, tbl[i].ra1);
            step();
            chk($sformatf("vec%0d_p0", i), bus_rd[0][W-1:0], tbl[i].x0);
            chk($sformatf("vec%0d_p1", i), bus_rd[0][2*W-1:W], tbl[i].x1);
            chk($sformatf("vec%0d_nz_p0", i), bus_rd[1][W-1:0], tbl[i].xnz0);
        end

        // Preload rk = k + 0x100, two registers per cycle.
        for (int k = 0; k < N; k += 2) begin
            set_wr(2'b11, k, k + 1, W'(k + 'h100), W'(k + 1 + 'h100));
            step();
        end
        set_wr(2'b00, 0, 0, '0, '0);

        // Dump with ready toggling and a start pulse in the middle.
        start = 1'b1; ready = 1'b0;
        step();
        start = 1'b0;
        begin
            int cyc;
            bit done;
            done = 0;
            for (cyc = 0; cyc < 200 && !done; cyc++) begin
                ready = (cyc % 2 == 0);
                start = (cyc == 21);
                #1;
                if (dvalid[1] && ready) hs_q.push_back('{int'(dindex[1]), ddata[1], dlast[1]});
                step();
                if (hs_q.size() == N && ready) begin
                    done = 1;
                    chk("busy_after_last", W'(dbusy[1]), '0);
                end
            end
            if (!done) chk("dump_timeout", W'(hs_q.size()), W'(N));
        end
        start = 1'b0; ready = 1'b0;
        chk("dump_word_count", W'(hs_q.size()), W'(N));
        for (int i = 0; i < hs_q.size(); i++) begin
            chk($sformatf("hs%0d_idx", i), W'(hs_q[i].idx), W'(i));
            chk($sformatf("hs%0d_data", i), hs_q[i].data, W'(i + 'h100));
            chk($sformatf("hs%0d_last", i), W'(hs_q[i].last), W'(i == N - 1));
        end
        step();
        chk("idle_after_dump", W'(dvalid[0]), '0);

        // Reset after 10 dump words aborts the dump and clears the bank.
        start = 1'b1; ready = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("index_before_reset", W'(dindex[0]), W'(10));
        rst = 1'b1;
        step();
        chk("reset_valid", W'(dvalid[0]), '0);
        chk("reset_busy", W'(dbusy[0]), '0);
        chk("reset_index", W'(dindex[0]), '0);
        rst = 1'b0; ready = 1'b0;
        for (int a = 0; a < N; a++) begin
            set_rd(a, a);
            step();
            chk("post_reset_rd", bus_rd[1][W-1:0], '0);
        end

        // Randomized traffic, biased toward address collisions.
        for (int i = 0; i < 600; i++) begin
            int lim;
            lim = ($urandom_range(0, 3) == 0) ? N - 1 : 3;
            set_wr(2'($urandom), $urandom_range(0, lim), $urandom_range(0, lim), $urandom, $urandom);
            set_rd($urandom_range(0, lim), $urandom_range(0, lim));
            start = ($urandom_range(0, 15) == 0);
            ready = $urandom_range(0, 1) == 1;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
